// File: rtl/tpu_pkg.sv
// Shared TPU definitions: collector FSM states and result-matrix geometry.
package tpu_pkg;

    // 2x2 result matrix, drained as four words
    localparam int MAT_WORDS = 4;
    localparam int IDX_W     = $clog2(MAT_WORDS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DRAIN  = 2'd2,
        CLEAR  = 2'd3
    } state_t;

endpackage

// File: rtl/relu_unit.sv
// Combinational ReLU: zeroes signed-negative words when enabled.
module relu_unit #(
    parameter int DATA_W = 8
) (
    input  logic              en,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    // MSB set means negative in two's complement
    assign dout = (en && din[DATA_W-1]) ? '0 : din;

endmodule

// File: rtl/result_collector.sv
// Collects the 2x2 accumulator matrix once both columns are full, optionally
// applies ReLU, streams the words row-major over valid/ready, then pulses
// acc_clear to reset the accumulators.
module result_collector
    import tpu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              acc0_full,
    input  logic              acc1_full,
    input  logic [DATA_W-1:0] acc0_mem_0,
    input  logic [DATA_W-1:0] acc0_mem_1,
    input  logic [DATA_W-1:0] acc1_mem_0,
    input  logic [DATA_W-1:0] acc1_mem_1,
    input  logic              relu_en,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_row,
    output logic              out_col,
    output logic              out_last,
    output logic              acc_clear,
    output logic              busy
);

    state_t state, state_nxt;

    // Words are indexed row-major: index = row*2 + col
    logic [MAT_WORDS-1:0][DATA_W-1:0] raw_w;
    logic [MAT_WORDS-1:0][DATA_W-1:0] relu_w;
    logic [MAT_WORDS-1:0][DATA_W-1:0] res_q;
    logic [IDX_W-1:0]                 rd_idx;

    logic both_full;
    logic capture;
    logic xfer;
    logic idx_last;
    logic last_xfer;

    assign both_full = acc0_full & acc1_full;

    // accC_mem_R holds result[R][C]
    assign raw_w[0] = acc0_mem_0;
    assign raw_w[1] = acc1_mem_0;
    assign raw_w[2] = acc0_mem_1;
    assign raw_w[3] = acc1_mem_1;

    // ReLU is applied on the way into the result register, so relu_en only
    // matters at the capture edge
    for (genvar g = 0; g < MAT_WORDS; g++) begin : g_relu
        relu_unit #(.DATA_W(DATA_W)) u_relu (
            .en   (relu_en),
            .din  (raw_w[g]),
            .dout (relu_w[g])
        );
    end

    assign out_valid = (state == DRAIN);
    assign xfer      = out_valid & out_ready;
    assign idx_last  = (rd_idx == IDX_W'(MAT_WORDS - 1));
    assign last_xfer = xfer & idx_last;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic; SETTLE gives the accumulators one cycle to copy
    // their final sums to the outputs before capture
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        case (state)
            IDLE:   if (both_full) state_nxt = SETTLE;
            SETTLE: begin
                if (both_full) begin
                    capture   = 1'b1;
                    state_nxt = DRAIN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            DRAIN:  if (last_xfer) state_nxt = CLEAR;
            CLEAR:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Result register, loaded once per matrix
    always_ff @(posedge clk or posedge reset) begin
        if (reset)        res_q <= '0;
        else if (capture) res_q <= relu_w;
    end

    // Read index advances only on an accepted beat; wraps to 0 after the last
    always_ff @(posedge clk or posedge reset) begin
        if (reset)        rd_idx <= '0;
        else if (capture) rd_idx <= '0;
        else if (xfer)    rd_idx <= rd_idx + 1'b1;
    end

    // Outputs are gated by DRAIN so they read zero whenever nothing is offered
    assign out_data  = out_valid ? res_q[rd_idx] : '0;
    assign out_row   = out_valid & rd_idx[1];
    assign out_col   = out_valid & rd_idx[0];
    assign out_last  = out_valid & idx_last;
    assign acc_clear = (state == CLEAR);
    assign busy      = (state != IDLE);

endmodule
